cga_mac_segpt_bank: RTL and testbench

- Parametrised successor of the MAC segment/page-table control register group.
- Holds one PCR per interrupt level instead of a single PCR.
- Drives the PCR of the currently active level onto the MAC datapath.
- Keeps the SEG and XPT/EXM registers, and adds a sequenced clear-all operation with busy/done handshake so microcode can reinitialise every level's PCR without issuing one write per level.

---
 rtl/cga_mac_segpt_bank.sv | 142 ++++++++++++++
 tb/tb_cga_mac_segpt_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_mac_segpt_bank.sv
// MAC segment/page-table register group with one PCR per interrupt level and
// a sequenced clear-all of the PCR bank. All state updates on the falling edge of MCLK.
module cga_mac_segpt_bank #(
    parameter int NLEVEL = 16,
    parameter int LVLW   = 4,
    parameter int PCRW   = 16,
    parameter int SEGW   = 8,
    parameter int XPTW   = 2
) (
    input  logic            MCLK,
    input  logic            RESETN,
    input  logic [PCRW-1:0] FIDBO,
    input  logic            LLDPCR,
    input  logic [LVLW-1:0] WLVL,
    input  logic [LVLW-1:0] CURLVL,
    input  logic            LLDSEG,
    input  logic            LLDEXM,
    input  logic            EXMN,
    input  logic            CLRREQ,
    output logic [PCRW-1:0] PCR,
    output logic [SEGW-1:0] SEG,
    output logic            SEGZN,
    output logic [XPTW-1:0] XPT,
    output logic            PEX,
    output logic            VEX,
    output logic            BUSY,
    output logic            DONE,
    output logic            LDERR
);

    // Handshake: BUSY is high for exactly NLEVEL cycles while entries are
    // cleared in index order; DONE then pulses for one cycle. PCR writes are
    // only accepted in IDLE; a write offered at any other time is dropped and
    // reported by a one-cycle LDERR pulse after the offending edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [LVLW-1:0] LAST_IDX = LVLW'(NLEVEL - 1);

    state_t          state_q;
    logic [LVLW-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            lderr_q;
    logic [PCRW-1:0] pcr_mem_q [NLEVEL];
    logic [PCRW-1:0] pcr_q;
    logic [PCRW-1:0] pcr_d;
    logic [SEGW-1:0] seg_q;
    logic [XPTW-1:0] xpt_q;
    logic            exmr_q;
    logic            wr_en;
    logic            clr_en;

    assign wr_en  = (state_q == S_IDLE) && LLDPCR;
    assign clr_en = (state_q == S_CLEAR);

    // PCR shows the active level's entry as it stands after this edge,
    // so a same-edge write or clear of that index is forwarded here.
    always_comb begin
        pcr_d = pcr_mem_q[CURLVL];
        if (wr_en && (WLVL == CURLVL)) begin
            pcr_d = FIDBO;
        end else if (clr_en && (cnt_q == CURLVL)) begin
            pcr_d = '0;
        end
    end

    always_ff @(negedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lderr_q <= 1'b0;
            pcr_q   <= '0;
            seg_q   <= '0;
            xpt_q   <= '0;
            exmr_q  <= 1'b0;
            for (int i = 0; i < NLEVEL; i++) begin
                pcr_mem_q[i] <= '0;
            end
        end else begin
            pcr_q   <= pcr_d;
            lderr_q <= LLDPCR && (state_q != S_IDLE);
            done_q  <= 1'b0;

            if (LLDSEG) begin
                seg_q <= FIDBO[SEGW-1:0];
            end
            if (LLDEXM) begin
                xpt_q  <= FIDBO[XPTW-1:0];
                exmr_q <= ~EXMN;
            end

            // Write precedes clear: both can only happen on different states.
            if (wr_en) begin
                pcr_mem_q[WLVL] <= FIDBO;
            end
            if (clr_en) begin
                pcr_mem_q[cnt_q] <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (CLRREQ) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + LVLW'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign PCR   = pcr_q;
    assign SEG   = seg_q;
    assign SEGZN = |seg_q;
    assign XPT   = xpt_q;
    assign PEX   = exmr_q & xpt_q[0];
    assign VEX   = exmr_q & xpt_q[1];
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign LDERR = lderr_q;

endmodule

// File: tb/tb_cga_mac_segpt_bank.sv
// Bench for cga_mac_segpt_bank: directed scenarios plus random traffic,
// checked each falling edge against a queue of expected register states.
module tb_cga_mac_segpt_bank;

  localparam int NLEVEL = 16;
  localparam int LVLW   = 4;
  localparam int PCRW   = 16;
  localparam int SEGW   = 8;
  localparam int XPTW   = 2;

  typedef struct packed {
    logic [PCRW-1:0] pcr;
    logic [SEGW-1:0] seg;
    logic            segzn;
    logic [XPTW-1:0] xpt;
    logic            pex;
    logic            vex;
    logic            busy;
    logic            done;
    logic            lderr;
  } exp_t;

  // clock / reset
  logic            mclk = 1'b0;
  logic            rstn = 1'b1;
  logic [PCRW-1:0] fidbo = '0;
  logic            lldpcr = 1'b0;
  logic [LVLW-1:0] wlvl = '0;
  logic [LVLW-1:0] curlvl = '0;
  logic            lldseg = 1'b0;
  logic            lldexm = 1'b0;
  logic            exmn = 1'b1;
  logic            clrreq = 1'b0;
  logic [PCRW-1:0] pcr;
  logic [SEGW-1:0] seg;
  logic            segzn;
  logic [XPTW-1:0] xpt;
  logic            pex;
  logic            vex;
  logic            busy;
  logic            done;
  logic            lderr;

  always #5 mclk = ~mclk;

  cga_mac_segpt_bank #(
    .NLEVEL(NLEVEL), .LVLW(LVLW), .PCRW(PCRW), .SEGW(SEGW), .XPTW(XPTW)
  ) dut (
    .MCLK(mclk), .RESETN(rstn), .FIDBO(fidbo), .LLDPCR(lldpcr), .WLVL(wlvl),
    .CURLVL(curlvl), .LLDSEG(lldseg), .LLDEXM(lldexm), .EXMN(exmn),
    .CLRREQ(clrreq), .PCR(pcr), .SEG(seg), .SEGZN(segzn), .XPT(xpt),
    .PEX(pex), .VEX(vex), .BUSY(busy), .DONE(done), .LDERR(lderr)
  );

  // reference model: bank contents plus clear progress as "edges remaining"
  int unsigned     total = 0;
  int unsigned     bad = 0;
  exp_t            exp_q[$];
  logic [PCRW-1:0] m_ent [NLEVEL];
  logic [SEGW-1:0] m_seg;
  logic [XPTW-1:0] m_xpt;
  logic            m_exm;
  int              m_mode;   // 0 idle, 1 clearing, 2 done
  int              m_rem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic model_step();
    exp_t e;
    e = '0;
    if (!rstn) begin
      for (int i = 0; i < NLEVEL; i++) m_ent[i] = '0;
      m_seg = '0; m_xpt = '0; m_exm = 1'b0; m_mode = 0; m_rem = 0;
    end else begin
      e.lderr = lldpcr && (m_mode != 0);
      if (m_mode == 0) begin
        if (lldpcr) m_ent[wlvl] = fidbo;
        if (clrreq) begin
          m_mode = 1;
          m_rem = NLEVEL;
        end
      end else if (m_mode == 1) begin
        m_ent[NLEVEL - m_rem] = '0;
        m_rem--;
        if (m_rem == 0) begin
          m_mode = 2;
          e.done = 1'b1;
        end
      end else begin
        m_mode = 0;
      end
      if (lldseg) m_seg = fidbo[SEGW-1:0];
      if (lldexm) begin
        m_xpt = fidbo[XPTW-1:0];
        m_exm = !exmn;
      end
    end
    e.pcr   = m_ent[curlvl];
    e.seg   = m_seg;
    e.segzn = (m_seg != 0);
    e.xpt   = m_xpt;
    e.pex   = m_exm && m_xpt[0];
    e.vex   = m_exm && m_xpt[1];
    e.busy  = (m_mode == 1);
    exp_q.push_back(e);
  endtask

  // driver tasks: inputs change on the rising edge, DUT acts on the falling edge
  task automatic drive(input logic lld, input logic [LVLW-1:0] wl, input logic [PCRW-1:0] fid,
                       input logic [LVLW-1:0] cur, input logic lseg, input logic lexm,
                       input logic exmn_v, input logic clr);
    @(posedge mclk);
    rstn = 1'b1;
    lldpcr = lld; wlvl = wl; fidbo = fid; curlvl = cur;
    lldseg = lseg; lldexm = lexm; exmn = exmn_v; clrreq = clr;
    model_step();
  endtask

  task automatic idle(input logic [LVLW-1:0] cur);
    drive(1'b0, '0, '0, cur, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge mclk);
    rstn = 1'b0;
    lldpcr = 1'b0; lldseg = 1'b0; lldexm = 1'b0; clrreq = 1'b0; exmn = 1'b1;
    model_step();
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_pcr", {16'd0, pcr}, 32'd0);
  endtask

  task automatic fill_all();
    for (int i = 0; i < NLEVEL; i++)
      drive(1'b1, LVLW'(i), PCRW'($urandom_range(1, 16'hFFFF)), LVLW'(i), 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic readback();
    for (int i = 0; i < NLEVEL; i++) idle(LVLW'(i));
  endtask

  // scoreboard monitor
  always begin
    exp_t e;
    @(negedge mclk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pcr", {16'd0, pcr}, {16'd0, e.pcr});
      chk("seg", {24'd0, seg}, {24'd0, e.seg});
      chk("segzn", {31'd0, segzn}, {31'd0, e.segzn});
      chk("xpt", {30'd0, xpt}, {30'd0, e.xpt});
      chk("pex", {31'd0, pex}, {31'd0, e.pex});
      chk("vex", {31'd0, vex}, {31'd0, e.vex});
      chk("busy", {31'd0, busy}, {31'd0, e.busy});
      chk("done", {31'd0, done}, {31'd0, e.done});
      chk("lderr", {31'd0, lderr}, {31'd0, e.lderr});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // 1: reset state
    do_reset();
    do_reset();
    idle('0);
    idle('0);

    // 2: write-through bypass, then switch levels
    drive(1'b1, 4'd3, 16'hA5C3, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4'd0);
    idle(4'd3);

    // 3: SEG loads ignore upper FIDBO bits
    drive(1'b0, '0, 16'h1200, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 16'h0040, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);

    // 4: XPT/EXM capture
    drive(1'b0, '0, 16'h0002, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 16'h0002, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0, 16'h0003, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: full clear with dropped write at the fifth busy cycle, watching level 7
    fill_all();
    drive(1'b0, '0, '0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < NLEVEL; i++) begin
      if (i == 4) drive(1'b1, 4'd12, 16'hBEEF, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      else idle(4'd7);
    end
    idle(4'd7);
    idle(4'd7);
    readback();

    // 6: reset in the middle of a clear
    fill_all();
    drive(1'b0, '0, '0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) idle(4'd9);
    do_reset();
    readback();
    fill_all();
    drive(1'b0, '0, '0, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < NLEVEL + 2; i++) idle(4'd15);
    readback();

    // write and clear request on the same idle edge
    drive(1'b1, 4'd5, 16'h1357, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < NLEVEL + 2; i++) idle(4'd5);

    // CLRREQ held high through DONE
    for (int i = 0; i < 2 * NLEVEL + 6; i++)
      drive(1'b0, '0, '0, LVLW'(i), 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < NLEVEL + 2; i++) idle(LVLW'(i));

    // random traffic
    for (int i = 0; i < 500; i++) begin
      drive(($urandom % 3) == 0, LVLW'($urandom), PCRW'($urandom), LVLW'($urandom),
            ($urandom % 4) == 0, ($urandom % 5) == 0, 1'($urandom), ($urandom % 40) == 0);
    end
    for (int i = 0; i < NLEVEL + 2; i++) idle(LVLW'(i));

    repeat (3) @(negedge mclk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
